// File: rtl/buck_loop_controller_pkg.sv
// Shared types, default widths and saturation helper for the buck loop controller.
package buck_ctrl_pkg;

    localparam int DATA_WIDTH_DEF    = 25;
    localparam int DECIMAL_WIDTH_DEF = 16;
    localparam int DUTY_WIDTH_DEF    = 16;
    localparam int MAX_DUTY_DEF      = 6000;

    // Internal arithmetic width: wide enough for any DATA_WIDTH x (DATA_WIDTH+1)
    // product plus headroom, so intermediate sums never wrap.
    localparam int WIDE_W = 64;
    typedef logic signed [WIDE_W-1:0] wide_t;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        SOFTSTART = 2'd1,
        REGULATE  = 2'd2,
        FAULT     = 2'd3
    } state_e;

    // Saturate x into [lo, hi] using signed comparison.
    function automatic wide_t clamp_wide(input wide_t x, input wide_t lo, input wide_t hi);
        if (x < lo) begin
            return lo;
        end else if (x > hi) begin
            return hi;
        end
        return x;
    endfunction

endpackage

// File: rtl/buck_loop_controller_if.sv
// Signal bundle between the loop controller and its environment.
// clock_enable is a one-cycle sample qualifier with no backpressure: the
// controller never stalls the sampler, it flags sample_overrun instead when a
// strobe lands while the PI pipeline is still busy.
interface buck_loop_controller_if #(
    parameter int DATA_WIDTH = 25,
    parameter int DUTY_WIDTH = 16
);
    logic                          clock_enable;
    logic                          enable;
    logic signed [DATA_WIDTH-1:0]  voltage_reference;
    logic signed [DATA_WIDTH-1:0]  output_voltage;
    logic signed [DATA_WIDTH-1:0]  inductor_current;
    logic signed [DATA_WIDTH-1:0]  current_limit;
    logic signed [DATA_WIDTH-1:0]  kp;
    logic signed [DATA_WIDTH-1:0]  ki;
    logic signed [DATA_WIDTH-1:0]  softstart_step;
    logic        [DUTY_WIDTH-1:0]  duty_cycle;
    logic        [1:0]             state;
    logic                          fault;
    logic                          sample_overrun;

    modport master (
        output clock_enable, enable, voltage_reference, output_voltage,
               inductor_current, current_limit, kp, ki, softstart_step,
        input  duty_cycle, state, fault, sample_overrun
    );

    modport slave (
        input  clock_enable, enable, voltage_reference, output_voltage,
               inductor_current, current_limit, kp, ki, softstart_step,
        output duty_cycle, state, fault, sample_overrun
    );
endinterface

// File: rtl/buck_loop_controller_pi_pipeline.sv
// Four-stage PI pipeline: error, gain products, clamped integrator, saturated duty.
module pi_pipeline
    import buck_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
    parameter int DECIMAL_WIDTH = DECIMAL_WIDTH_DEF,
    parameter int DUTY_WIDTH    = DUTY_WIDTH_DEF,
    parameter int MAX_DUTY      = MAX_DUTY_DEF
) (
    input  logic                          aclk,
    input  logic                          reset,
    input  logic                          flush_i,
    input  logic                          start_i,
    input  logic signed [DATA_WIDTH-1:0]  ref_i,
    input  logic signed [DATA_WIDTH-1:0]  vout_i,
    input  logic signed [DATA_WIDTH-1:0]  kp_i,
    input  logic signed [DATA_WIDTH-1:0]  ki_i,
    output logic                          busy_o,
    output logic        [DUTY_WIDTH-1:0]  duty_o
);
    localparam int    ERR_W     = DATA_WIDTH + 1;
    localparam int    PROD_W    = DATA_WIDTH + ERR_W;
    localparam wide_t INTEG_MAX = wide_t'(MAX_DUTY) <<< DECIMAL_WIDTH;
    localparam wide_t DUTY_MAX  = wide_t'(MAX_DUTY);

    logic                     v1_q, v2_q, v3_q;
    logic signed [ERR_W-1:0]  err_q, err_d;
    logic signed [PROD_W-1:0] kp_w, ki_w, err_w, p_prod, i_prod;
    wide_t                    p_q, p_d, iinc_q, iinc_d, p3_q, integ_q, integ_d, u_sat;
    logic [DUTY_WIDTH-1:0]    duty_q, duty_d;

    // Stage datapaths: sign-extended operands so no stage can wrap.
    always_comb begin
        err_d   = $signed({ref_i[DATA_WIDTH-1], ref_i}) - $signed({vout_i[DATA_WIDTH-1], vout_i});
        kp_w    = {{(PROD_W-DATA_WIDTH){kp_i[DATA_WIDTH-1]}}, kp_i};
        ki_w    = {{(PROD_W-DATA_WIDTH){ki_i[DATA_WIDTH-1]}}, ki_i};
        err_w   = {{(PROD_W-ERR_W){err_q[ERR_W-1]}}, err_q};
        p_prod  = kp_w * err_w;
        i_prod  = ki_w * err_w;
        p_d     = wide_t'(p_prod >>> DECIMAL_WIDTH);
        iinc_d  = wide_t'(i_prod >>> DECIMAL_WIDTH);
        integ_d = clamp_wide(integ_q + iinc_q, '0, INTEG_MAX);
        u_sat   = clamp_wide((p3_q + integ_q) >>> DECIMAL_WIDTH, '0, DUTY_MAX);
        duty_d  = u_sat[DUTY_WIDTH-1:0];
    end

    // Pipeline registers; a flush drops in-flight samples and zeroes integrator and duty.
    always_ff @(posedge aclk) begin
        if (reset || flush_i) begin
            v1_q    <= 1'b0;
            v2_q    <= 1'b0;
            v3_q    <= 1'b0;
            err_q   <= '0;
            p_q     <= '0;
            iinc_q  <= '0;
            p3_q    <= '0;
            integ_q <= '0;
            duty_q  <= '0;
        end else begin
            v1_q <= start_i;
            v2_q <= v1_q;
            v3_q <= v2_q;
            if (start_i) begin
                err_q <= err_d;
            end
            if (v1_q) begin
                p_q    <= p_d;
                iinc_q <= iinc_d;
            end
            if (v2_q) begin
                integ_q <= integ_d;
                p3_q    <= p_q;
            end
            if (v3_q) begin
                duty_q <= duty_d;
            end
        end
    end

    assign busy_o = v1_q | v2_q | v3_q;
    assign duty_o = duty_q;

endmodule

// File: rtl/buck_loop_controller.sv
// Buck loop controller top: mode FSM, soft-start reference, over-current trip, overrun flag.
module buck_loop_controller
    import buck_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
    parameter int DECIMAL_WIDTH = DECIMAL_WIDTH_DEF,
    parameter int DUTY_WIDTH    = DUTY_WIDTH_DEF,
    parameter int MAX_DUTY      = MAX_DUTY_DEF
) (
    input  logic                   aclk,
    input  logic                   reset,
    buck_loop_controller_if.slave  bus
);
    state_e                       state_q, state_d;
    logic signed [DATA_WIDTH-1:0] ref_active_q, ref_active_d;
    logic                         overrun_q, overrun_d;
    logic signed [DATA_WIDTH:0]   ss_sum, vref_ext;
    logic                         trip, busy, flush, start;
    logic [DUTY_WIDTH-1:0]        duty;

    // Next-state, reference and pipeline control; disable beats fault beats strobe.
    always_comb begin
        state_d      = state_q;
        ref_active_d = ref_active_q;
        ss_sum       = $signed({ref_active_q[DATA_WIDTH-1], ref_active_q})
                     + $signed({bus.softstart_step[DATA_WIDTH-1], bus.softstart_step});
        vref_ext     = $signed({bus.voltage_reference[DATA_WIDTH-1], bus.voltage_reference});
        trip         = bus.clock_enable && (bus.inductor_current > bus.current_limit)
                     && (state_q != FAULT);
        if (!bus.enable) begin
            state_d      = IDLE;
            ref_active_d = '0;
        end else if (trip) begin
            state_d      = FAULT;
            ref_active_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d      = SOFTSTART;
                    ref_active_d = '0;
                end
                SOFTSTART: begin
                    if (bus.clock_enable) begin
                        if (ss_sum >= vref_ext) begin
                            ref_active_d = bus.voltage_reference;
                            state_d      = REGULATE;
                        end else begin
                            ref_active_d = ss_sum[DATA_WIDTH-1:0];
                        end
                    end
                end
                REGULATE: begin
                    if (bus.clock_enable) begin
                        ref_active_d = bus.voltage_reference;
                    end
                end
                default: begin
                    state_d = FAULT;
                end
            endcase
        end
        flush     = (state_d == IDLE) || (state_d == FAULT);
        start     = bus.clock_enable && !busy && !flush
                  && ((state_q == SOFTSTART) || (state_q == REGULATE));
        overrun_d = overrun_q | (bus.clock_enable && busy);
    end

    // State, active reference and sticky overrun registers.
    always_ff @(posedge aclk) begin
        if (reset) begin
            state_q      <= IDLE;
            ref_active_q <= '0;
            overrun_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            ref_active_q <= ref_active_d;
            overrun_q    <= overrun_d;
        end
    end

    pi_pipeline #(
        .DATA_WIDTH    (DATA_WIDTH),
        .DECIMAL_WIDTH (DECIMAL_WIDTH),
        .DUTY_WIDTH    (DUTY_WIDTH),
        .MAX_DUTY      (MAX_DUTY)
    ) u_pi (
        .aclk    (aclk),
        .reset   (reset),
        .flush_i (flush),
        .start_i (start),
        .ref_i   (ref_active_q),
        .vout_i  (bus.output_voltage),
        .kp_i    (bus.kp),
        .ki_i    (bus.ki),
        .busy_o  (busy),
        .duty_o  (duty)
    );

    assign bus.duty_cycle     = duty;
    assign bus.state          = state_q;
    assign bus.fault          = (state_q == FAULT);
    assign bus.sample_overrun = overrun_q;

endmodule
